// File: rtl/pgm_video_pkg.sv
// Shared types for the PGM video engine's graphics-ROM read path.
package pgm_video_pkg;

  localparam int PGM_DDR_BURST = 4;
  localparam int PGM_DDR_AW    = 29;

  typedef logic [PGM_DDR_AW-1:0] ddr_addr_t;
  typedef logic [63:0]           ddr_word_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } rd_state_e;

endpackage

// File: rtl/pgm_line_cache.sv
// One-line read cache: BURST x 64-bit line storage, tag/valid and hit comparator.
module pgm_line_cache
  import pgm_video_pkg::*;
#(
  parameter int BURST = PGM_DDR_BURST,
  parameter int AW    = PGM_DDR_AW
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [AW-1:0]                 lookup_addr,
  output logic                          hit,
  output ddr_word_t                     lookup_data,
  input  logic                          wr_en,
  input  logic [$clog2(BURST)-1:0]      wr_idx,
  input  ddr_word_t                     wr_data,
  input  logic                          tag_wr,
  input  logic [AW-$clog2(BURST)-1:0]   tag_value,
  input  logic                          valid_value,
  input  logic                          invalidate
);

  localparam int OW = $clog2(BURST);
  localparam int TW = AW - OW;

  ddr_word_t         line [BURST];
  logic [TW-1:0]     tag;
  logic              valid;

  // Tag and valid only change on a completed refill or an idle-time flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
    end else if (tag_wr) begin
      valid <= valid_value;
      tag   <= tag_value;
    end else if (invalidate) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line[wr_idx] <= wr_data;
    end
  end

  assign hit         = valid && (tag == lookup_addr[AW-1:OW]);
  assign lookup_data = line[lookup_addr[OW-1:0]];

endmodule

// File: rtl/pgm_ddram_rd_bridge.sv
// Graphics-ROM read responder: serves single-word reads from a one-line cache,
// refilling it with an aligned Avalon burst on a miss.
module pgm_ddram_rd_bridge
  import pgm_video_pkg::*;
#(
  parameter int BURST = PGM_DDR_BURST,
  parameter int AW    = PGM_DDR_AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ddram_rd,
  input  logic [AW-1:0]   ddram_addr,
  output ddr_word_t       ddram_dout,
  output logic            ddram_dout_ready,
  output logic            ddram_busy,
  input  logic            flush,
  output logic            mem_rd,
  output logic [AW-1:0]   mem_addr,
  output logic [7:0]      mem_burstcnt,
  input  logic            mem_waitrequest,
  input  ddr_word_t       mem_dout,
  input  logic            mem_dout_ready
);

  localparam int          OW        = $clog2(BURST);
  localparam int          TW        = AW - OW;
  localparam logic [7:0]  BURST_CNT = 8'(BURST);
  localparam logic [OW-1:0] LAST_BEAT = OW'(BURST - 1);

  rd_state_e      state;
  logic [OW-1:0]  fill_cnt;
  logic [OW-1:0]  lat_off;
  logic [TW-1:0]  lat_tag;
  logic           flush_pend;

  logic           cache_hit;
  ddr_word_t      cache_data;
  logic           cache_wr;
  logic           cache_tag_wr;
  logic           cache_invalidate;

  assign cache_wr         = (state == FILL) && mem_dout_ready;
  assign cache_tag_wr     = cache_wr && (fill_cnt == LAST_BEAT);
  assign cache_invalidate = (state == IDLE) && flush;

  pgm_line_cache #(
    .BURST (BURST),
    .AW    (AW)
  ) u_line_cache (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (ddram_addr),
    .hit         (cache_hit),
    .lookup_data (cache_data),
    .wr_en       (cache_wr),
    .wr_idx      (fill_cnt),
    .wr_data     (mem_dout),
    .tag_wr      (cache_tag_wr),
    .tag_value   (lat_tag),
    .valid_value (~(flush_pend | flush)),
    .invalidate  (cache_invalidate)
  );

  // A flush arriving mid-refill is remembered so the finished line is left invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      fill_cnt         <= '0;
      lat_off          <= '0;
      lat_tag          <= '0;
      flush_pend       <= 1'b0;
      ddram_dout       <= '0;
      ddram_dout_ready <= 1'b0;
      ddram_busy       <= 1'b0;
      mem_rd           <= 1'b0;
      mem_addr         <= '0;
      mem_burstcnt     <= '0;
    end else begin
      ddram_dout_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ddram_rd) begin
            if (cache_hit && !flush) begin
              ddram_dout       <= cache_data;
              ddram_dout_ready <= 1'b1;
            end else begin
              lat_off      <= ddram_addr[OW-1:0];
              lat_tag      <= ddram_addr[AW-1:OW];
              ddram_busy   <= 1'b1;
              mem_rd       <= 1'b1;
              mem_addr     <= {ddram_addr[AW-1:OW], {OW{1'b0}}};
              mem_burstcnt <= BURST_CNT;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          if (flush) begin
            flush_pend <= 1'b1;
          end
          if (!mem_waitrequest) begin
            mem_rd       <= 1'b0;
            mem_burstcnt <= '0;
            fill_cnt     <= '0;
            state        <= FILL;
          end
        end
        FILL: begin
          if (flush) begin
            flush_pend <= 1'b1;
          end
          if (mem_dout_ready) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == lat_off) begin
              ddram_dout <= mem_dout;
            end
            if (fill_cnt == LAST_BEAT) begin
              flush_pend       <= 1'b0;
              ddram_dout_ready <= 1'b1;
              ddram_busy       <= 1'b0;
              state            <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pgm_ddram_rd_bridge.md
Name: pgm_ddram_rd_bridge

Overview:
- Responder side of the video engine's graphics-ROM read port (ddram_rd / ddram_addr / ddram_dout / ddram_busy).
- Accepts single-word read requests from the sprite and tile fetchers and serves them from a one-line read cache.
- On a cache miss it issues an aligned burst read on the MiSTer DDR3 Avalon-style master port and refills the line.
- Sits between pgm_video and the top-level DDRAM_* arbiter port, all in the video clock domain.

Parameters:
- BURST, 4: 64-bit words per cache line and per DDR burst; power of two, 2..16.
- AW, 29: word address width, identical on both sides.

Ports:
- clk  in  1  video/system clock.
- reset  in  1  asynchronous, active-high reset.
- ddram_rd  in  1  single-cycle read request; sampled only while ddram_busy=0.
- ddram_addr  in  AW  64-bit word address, valid with ddram_rd.
- ddram_dout  out  64  read data; holds its value until the next response.
- ddram_dout_ready  out  1  one-cycle pulse, ddram_dout valid.
- ddram_busy  out  1  1 = new requests are not accepted.
- flush  in  1  invalidate cache (ROM loader wrote DDR).
- mem_rd  out  1  Avalon read, held until accepted.
- mem_addr  out  AW  line-aligned burst address.
- mem_burstcnt  out  8  equals BURST during mem_rd.
- mem_waitrequest  in  1  Avalon waitrequest.
- mem_dout  in  64  burst beat data.
- mem_dout_ready  in  1  beat valid.

Behaviour:
- Reset values (asynchronous): ddram_dout=0, ddram_dout_ready=0, ddram_busy=0, mem_rd=0, mem_addr=0, mem_burstcnt=0. Internal: valid=0, tag=0, state=IDLE, fill_cnt=0, flush_pend=0.
- Address split: off = addr[log2(BURST)-1:0]; tag = addr[AW-1:log2(BURST)].
- State IDLE (busy=0):
  - A hit is ddram_rd=1, valid=1 and tag match.
  - On a hit, at the same edge: ddram_dout <= line[off], ddram_dout_ready <= 1. Latency is 1 cycle, busy stays 0, and back-to-back hits run at one per clock.
  - On a miss: latch off and tag, set busy <= 1, mem_rd <= 1, mem_addr <= {tag, zeros}, mem_burstcnt <= BURST, then go to REQ. There is no dout_ready pulse for a miss.
- State REQ: hold mem_rd, mem_addr and mem_burstcnt while mem_waitrequest=1. At the first edge with mem_waitrequest=0, set mem_rd <= 0, mem_burstcnt <= 0, fill_cnt <= 0, then go to FILL.
- State FILL:
  - Each mem_dout_ready beat writes line[fill_cnt] <= mem_dout and increments fill_cnt.
  - When fill_cnt==off, also capture the beat into ddram_dout.
  - On the beat where fill_cnt==BURST-1: tag <= latched tag, valid <= ~(flush_pend|flush), flush_pend <= 0, ddram_dout_ready <= 1, busy <= 0, then go to IDLE.
  - Miss latency therefore ends one edge after the last beat.
- ddram_dout_ready is 0 in every cycle not listed above.
- ddram_rd while busy=1 is ignored: no response and no state change. Requesters must wait for busy=0.
- flush:
  - In IDLE, flush sets valid <= 0. If ddram_rd arrives in the same cycle, flush wins and the request is treated as a miss.
  - In REQ or FILL, flush sets flush_pend. The line completes and its response is delivered, but the line is left invalid.
- mem_dout_ready in IDLE or REQ is ignored.
- Reset mid-operation returns to reset state immediately and drops the burst. Reset is system-wide and also resets the DDR controller, so no stale beats are drained.
- fill_cnt is log2(BURST) bits and wraps only on the terminal beat.

Decomposition:
- Shared package pgm_video_pkg holds:
  - typedef ddr_addr_t (AW bits) and ddr_word_t (64 bits);
  - enum rd_state_e {IDLE, REQ, FILL};
  - localparam PGM_DDR_BURST = 4.
- Natural sub-module: pgm_line_cache, the BURST x 64 register array with tag/valid and write-port/read-port logic, plus the hit comparator. The FSM and Avalon handshake stay in the top module.

Test Plan:
- Cold miss: reset, rd addr=0x000105, waitrequest=1 for 3 cycles. Required: mem_rd stays high with mem_addr=0x000104 and burstcnt=4. Then beats D0..D3 = 0x11..0x44 produce one dout_ready one cycle after the last beat, with dout=0x22 and busy high from the edge after rd until that edge.
- Hit streaming: after the cold miss, rd addr=0x104, 0x107, 0x106 on consecutive cycles. Required: dout=0x11, 0x44, 0x33 on consecutive cycles, busy=0 throughout, mem_rd never asserted.
- Tag change: rd 0x108 after the line 0x104 fill. Required: miss, mem_addr=0x108; a following rd 0x104 misses again with mem_addr=0x104.
- Flush during FILL: assert flush on beat 2 of a fill for 0x200. Required: response still delivered; the next rd 0x201 misses with mem_addr=0x200.
- Flush and rd in the same IDLE cycle on a cached line. Required: treated as a miss and a burst issued. A rd during busy=1 produces no extra response or burst.
- Reset during FILL after 2 beats. Required: all outputs return to 0 asynchronously. A rd to the same line then misses, and a full 4-beat refill returns the correct word.
